// File: rtl/cb_obi_master_arbiter.sv
// OBI master arbiter: round-robin sharing of one OBI master port among NMASTER
// requesters, with an in-order FIFO that routes each rvalid back to its issuer.
package cb_obi_pkg;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module cb_obi_master_arbiter
   import cb_obi_pkg::*;
#(
   parameter int unsigned NMASTER         = 3,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  obi_req_t                           mst_req_i  [NMASTER],
   output obi_resp_t                          mst_resp_o [NMASTER],
   output obi_req_t                           slv_req_o,
   input  obi_resp_t                          slv_resp_i,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
   output logic                               err_o
);

   localparam int unsigned IdxW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
   localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic {StIdle, StLocked} state_e;

   state_e          state_q;
   logic [IdxW-1:0] lock_idx_q;
   logic [IdxW-1:0] rr_ptr_q;
   logic [IdxW-1:0] fifo_q [MAX_OUTSTANDING];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] count_q;
   logic            err_q;

   logic [IdxW-1:0] sel;
   logic [IdxW-1:0] head;
   logic            sel_valid;
   logic            full;
   logic            req_out;
   logic            push;
   logic            pop;

   // While locked the address phase must stay on the same master until gnt.
   always_comb begin
      int unsigned cand;
      sel       = lock_idx_q;
      sel_valid = 1'b0;
      cand      = 0;
      if (state_q == StLocked) begin
         sel_valid = 1'b1;
      end else begin
         for (int unsigned i = 0; i < NMASTER; i++) begin
            cand = (32'(rr_ptr_q) + i) % NMASTER;
            if (!sel_valid && mst_req_i[cand].req) begin
               sel       = IdxW'(cand);
               sel_valid = 1'b1;
            end
         end
      end
   end

   assign full    = (count_q == CntW'(MAX_OUTSTANDING));
   // A locked master already owns the port, so the full-FIFO block is idle-only.
   assign req_out = rst_ni & sel_valid & mst_req_i[sel].req & ((state_q == StLocked) | ~full);
   assign push    = req_out & slv_resp_i.gnt;
   assign pop     = rst_ni & slv_resp_i.rvalid & (count_q != '0);
   assign head    = fifo_q[rptr_q];

   always_comb begin
      slv_req_o     = mst_req_i[sel];
      slv_req_o.req = req_out;
   end

   always_comb begin
      for (int unsigned i = 0; i < NMASTER; i++) begin
         mst_resp_o[i].gnt    = push & (sel == IdxW'(i));
         mst_resp_o[i].rvalid = pop & (head == IdxW'(i));
         mst_resp_o[i].rdata  = slv_resp_i.rdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         lock_idx_q <= '0;
         rr_ptr_q   <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         case (state_q)
            StIdle: begin
               if (req_out && !slv_resp_i.gnt) begin
                  state_q    <= StLocked;
                  lock_idx_q <= sel;
               end
            end
            StLocked: begin
               if (slv_resp_i.gnt) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase

         if (push) begin
            fifo_q[wptr_q] <= sel;
            wptr_q         <= wptr_q + PtrW'(1);
            rr_ptr_q       <= (sel == IdxW'(NMASTER - 1)) ? '0 : sel + IdxW'(1);
         end
         if (pop) rptr_q <= rptr_q + PtrW'(1);

         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase

         // Response with nothing outstanding is a protocol violation; sticky.
         if (slv_resp_i.rvalid && count_q == '0) err_q <= 1'b1;
      end
   end

   assign outstanding_o = count_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_cb_obi_master_arbiter.sv
// Self-checking bench for cb_obi_master_arbiter: round-robin model plus a
// scoreboard of expected rvalid destinations.
module tb_cb_obi_master_arbiter;
   import cb_obi_pkg::*;

   localparam int NM = 3;
   localparam int MO = 4;

   logic      clk;
   logic      rst_n;
   obi_req_t  mreq  [NM];
   obi_resp_t mresp [NM];
   obi_req_t  sreq;
   obi_resp_t sresp;
   logic [2:0] outst;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;
   int rr_exp = 0;
   int exp_q[$];
   logic [31:0] addr_tab [NM] = '{32'h0000_2000, 32'h0000_1000, 32'h0000_3000};

   cb_obi_master_arbiter #(
      .NMASTER        (NM),
      .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mst_req_i    (mreq),
      .mst_resp_o   (mresp),
      .slv_req_o    (sreq),
      .slv_resp_i   (sresp),
      .outstanding_o(outst),
      .err_o        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gnt_idx();
      int r = -1;
      for (int i = 0; i < NM; i++) if (mresp[i].gnt) r = (r == -1) ? i : -2;
      return r;
   endfunction

   function automatic int rv_idx();
      int r = -1;
      for (int i = 0; i < NM; i++) if (mresp[i].rvalid) r = (r == -1) ? i : -2;
      return r;
   endfunction

   function automatic int rr_pick(input logic [NM-1:0] mask);
      for (int i = 0; i < NM; i++) begin
         int c = (rr_exp + i) % NM;
         if (mask[c]) return c;
      end
      return -1;
   endfunction

   task automatic drive(input logic [NM-1:0] mask, input logic g, input logic rv,
                        input logic [31:0] rd);
      for (int i = 0; i < NM; i++) begin
         mreq[i].req   = mask[i];
         mreq[i].we    = 1'b0;
         mreq[i].be    = 4'hF;
         mreq[i].addr  = addr_tab[i];
         mreq[i].wdata = 32'(i);
      end
      sresp.gnt    = g;
      sresp.rvalid = rv;
      sresp.rdata  = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_drain(input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         logic [31:0] d = base + 32'(k);
         int e, r;
         drive('0, 1'b0, 1'b1, d);
         @(negedge clk);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
         r = rv_idx();
         n_cmp++;
         if (r !== e) begin
            n_bad++;
            $display("FAIL drain_rvalid_dest: got master %0d, want %0d", r, e);
         end
         n_cmp++;
         if (mresp[NM-1].rdata !== d) begin
            n_bad++;
            $display("FAIL drain_rdata: got %h, want %h", mresp[NM-1].rdata, d);
         end
         tick();
      end
      drive('0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive('1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      n_cmp++;
      if (sreq.req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", sreq.req); end
      n_cmp++;
      if (gnt_idx() !== -1) begin n_bad++; $display("FAIL reset_gnt: got %0d want -1", gnt_idx()); end
      n_cmp++;
      if (outst !== 3'd0) begin n_bad++; $display("FAIL reset_outst: got %0d want 0", outst); end
      n_cmp++;
      if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      rr_exp = 0;
   endtask

   task automatic test_round_robin();
      int want [4] = '{0, 1, 2, 0};
      drive('1, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         int e = rr_pick('1);
         int g;
         @(negedge clk);
         g = gnt_idx();
         n_cmp++;
         if (g !== want[k] || e !== want[k]) begin
            n_bad++;
            $display("FAIL rr_grant[%0d]: got %0d, want %0d", k, g, want[k]);
         end
         exp_q.push_back(e);
         rr_exp = (e + 1) % NM;
         tick();
      end
      drive('0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (outst !== 3'd4) begin n_bad++; $display("FAIL rr_outst: got %0d want 4", outst); end
      test_drain(4, 32'h100);
   endtask

   task automatic test_locked();
      drive(3'b011, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (sreq.req !== 1'b1 || sreq.addr !== 32'h1000 || gnt_idx() !== -1) begin
            n_bad++;
            $display("FAIL lock_hold[%0d]: got req %b addr %h gnt %0d, want 1 00001000 -1",
                     k, sreq.req, sreq.addr, gnt_idx());
         end
         tick();
      end
      drive(3'b011, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      n_cmp++;
      if (gnt_idx() !== 1 || sreq.addr !== 32'h1000) begin
         n_bad++;
         $display("FAIL lock_gnt: got %0d addr %h, want 1 00001000", gnt_idx(), sreq.addr);
      end
      exp_q.push_back(1);
      rr_exp = 2;
      tick();
      drive(3'b001, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      n_cmp++;
      if (gnt_idx() !== 0 || sreq.addr !== 32'h2000) begin
         n_bad++;
         $display("FAIL lock_next: got %0d addr %h, want 0 00002000", gnt_idx(), sreq.addr);
      end
      exp_q.push_back(0);
      rr_exp = 1;
      tick();
      test_drain(2, 32'h200);
   endtask

   task automatic test_ordering();
      logic [NM-1:0] masks [3] = '{3'b100, 3'b001, 3'b010};
      int e, r;
      for (int k = 0; k < 3; k++) begin
         e = rr_pick(masks[k]);
         drive(masks[k], 1'b1, 1'b0, 32'h0);
         @(negedge clk);
         n_cmp++;
         if (gnt_idx() !== e) begin n_bad++; $display("FAIL ord_gnt[%0d]: got %0d want %0d", k, gnt_idx(), e); end
         exp_q.push_back(e);
         rr_exp = (e + 1) % NM;
         tick();
      end
      // Simultaneous push and pop.
      drive(3'b001, 1'b1, 1'b1, 32'hA);
      @(negedge clk);
      e = exp_q.pop_front();
      r = rv_idx();
      n_cmp++;
      if (r !== 2 || e !== 2 || mresp[2].rdata !== 32'hA) begin
         n_bad++;
         $display("FAIL ord_first: got master %0d rdata %h, want 2 0000000a", r, mresp[2].rdata);
      end
      e = rr_pick(3'b001);
      n_cmp++;
      if (gnt_idx() !== e) begin n_bad++; $display("FAIL ord_pushpop_gnt: got %0d want %0d", gnt_idx(), e); end
      exp_q.push_back(e);
      rr_exp = (e + 1) % NM;
      tick();
      n_cmp++;
      if (outst !== 3'd3) begin n_bad++; $display("FAIL ord_pushpop_outst: got %0d want 3", outst); end
      test_drain(3, 32'hB);
   endtask

   task automatic test_full();
      int e;
      drive('1, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         e = rr_pick('1);
         @(negedge clk);
         n_cmp++;
         if (gnt_idx() !== e) begin n_bad++; $display("FAIL full_fill[%0d]: got %0d want %0d", k, gnt_idx(), e); end
         exp_q.push_back(e);
         rr_exp = (e + 1) % NM;
         tick();
      end
      @(negedge clk);
      n_cmp++;
      if (sreq.req !== 1'b0 || outst !== 3'd4) begin
         n_bad++;
         $display("FAIL full_block: got req %b outst %0d, want 0 4", sreq.req, outst);
      end
      tick();
      drive('1, 1'b1, 1'b1, 32'h55);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (sreq.req !== 1'b0 || rv_idx() !== e) begin
         n_bad++;
         $display("FAIL full_pop: got req %b rvalid %0d, want 0 %0d", sreq.req, rv_idx(), e);
      end
      tick();
      drive('1, 1'b1, 1'b0, 32'h0);
      e = rr_pick('1);
      @(negedge clk);
      n_cmp++;
      if (gnt_idx() !== e) begin n_bad++; $display("FAIL full_resume: got %0d want %0d", gnt_idx(), e); end
      exp_q.push_back(e);
      rr_exp = (e + 1) % NM;
      tick();
      drive('0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (outst !== 3'd4) begin n_bad++; $display("FAIL full_refill: got %0d want 4", outst); end
      test_drain(4, 32'h300);
   endtask

   task automatic test_err();
      drive('0, 1'b0, 1'b1, 32'h77);
      @(negedge clk);
      n_cmp++;
      if (rv_idx() !== -1) begin n_bad++; $display("FAIL err_route: got %0d want -1", rv_idx()); end
      tick();
      drive('0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (err !== 1'b1 || outst !== 3'd0) begin
         n_bad++;
         $display("FAIL err_set: got err %b outst %0d, want 1 0", err, outst);
      end
      repeat (3) tick();
      n_cmp++;
      if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err); end
      tick();
      rst_n  = 1'b1;
      rr_exp = 0;
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int e;
      for (int k = 0; k < 2; k++) begin
         e = rr_pick(3'b110);
         drive(3'b110, 1'b1, 1'b0, 32'h0);
         @(negedge clk);
         n_cmp++;
         if (gnt_idx() !== e) begin n_bad++; $display("FAIL mid_gnt[%0d]: got %0d want %0d", k, gnt_idx(), e); end
         rr_exp = (e + 1) % NM;
         tick();
      end
      drive('0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (outst !== 3'd2) begin n_bad++; $display("FAIL mid_outst: got %0d want 2", outst); end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      drive('1, 1'b0, 1'b0, 32'h0);
      #1;
      n_cmp++;
      if (outst !== 3'd0 || sreq.req !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_async: got outst %0d req %b, want 0 0", outst, sreq.req);
      end
      tick();
      rst_n  = 1'b1;
      rr_exp = 0;
      drive('0, 1'b0, 1'b1, 32'h99);
      @(negedge clk);
      n_cmp++;
      if (rv_idx() !== -1) begin n_bad++; $display("FAIL mid_stray_route: got %0d want -1", rv_idx()); end
      tick();
      n_cmp++;
      if (err !== 1'b1) begin n_bad++; $display("FAIL mid_stray_err: got %b want 1", err); end
      drive('1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      n_cmp++;
      if (gnt_idx() !== 0) begin n_bad++; $display("FAIL mid_first_gnt: got %0d want 0", gnt_idx()); end
      exp_q.push_back(0);
      rr_exp = 1;
      tick();
      drive('0, 1'b0, 1'b0, 32'h0);
      test_drain(1, 32'h400);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_locked();
      test_ordering();
      test_full();
      test_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cb_obi_master_arbiter.md
CB_OBI_MASTER_ARBITER -- requirements
Module: cb_obi_master_arbiter

Interface
REQ-001 SHALL have parameter NMASTER, default 3; number of OBI masters sharing the port (0 = core instr, 1 = core data, 2 = debug).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4; outstanding-transaction FIFO depth, power of two, 2..16.
REQ-003 SHALL have port clk_i, input, 1 bit; the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit; reset, asynchronous and active-low.
REQ-005 SHALL have port mst_req_i, input, NMASTER x obi_req_t; per-master req, we, be[3:0], addr[31:0], wdata[31:0].
REQ-006 SHALL have port mst_resp_o, output, NMASTER x obi_resp_t; per-master gnt, rvalid, rdata[31:0].
REQ-007 SHALL have port slv_req_o, output, obi_req_t; request to the shared external xbar master port.
REQ-008 SHALL have port slv_resp_i, input, obi_resp_t; response from the shared port.
REQ-009 SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING)+1 bits; current outstanding count.
REQ-010 SHALL have port err_o, output, 1 bit; sticky protocol error (rvalid with no outstanding transaction).

Function
REQ-011 SHALL select one requesting master per cycle by round-robin; the search starts at rr_ptr, the index after the last granted master.
REQ-012 SHALL drive slv_req_o with the selected master's fields combinationally, and SHALL drive slv_req_o.req=0 when no master is selected.
REQ-013 SHALL hold the selection in a LOCKED state once slv_req_o.req=1 and slv_resp_i.gnt=0, so the OBI address phase stays stable until gnt.
REQ-014 State machine: IDLE -> LOCKED on req without gnt; LOCKED -> IDLE on gnt; IDLE -> IDLE on same-cycle req+gnt.
REQ-015 SHALL assert mst_resp_o[i].gnt = slv_resp_i.gnt AND (selected == i) AND slv_req_o.req; gnt to all other masters SHALL be 0.
REQ-016 SHALL, on each handshake (req and gnt), push the master index into the FIFO and set rr_ptr = (index+1) mod NMASTER.
REQ-017 SHALL gate slv_req_o.req to 0 when outstanding == MAX_OUTSTANDING, even if rvalid arrives in the same cycle.
REQ-018 SHALL NOT apply the full-FIFO block to a master already in LOCKED state; that master retains its selection and simply waits.
REQ-019 SHALL route slv_resp_i.rvalid only to mst_resp_o[head].rvalid and pop the FIFO in the same cycle; rdata SHALL be broadcast to all masters.
REQ-020 SHALL, on a simultaneous push and pop, leave outstanding unchanged and order the FIFO correctly (pop the old head, append the new entry).
REQ-021 SHALL, on rvalid while outstanding == 0, set err_o=1, route rvalid to no master and leave the FIFO unchanged.
REQ-022 SHALL keep err_o set until reset.
REQ-023 SHALL wrap FIFO pointers modulo MAX_OUTSTANDING.
REQ-024 SHALL add zero-cycle latency on both the request and response paths.

Reset
REQ-025 SHALL, while rst_ni=0 (asynchronous), set state=IDLE, rr_ptr=0, FIFO empty, outstanding_o=0, err_o=0, slv_req_o.req=0 and all mst_resp_o.gnt/rvalid=0.
REQ-026 SHALL, on reset mid-transaction, discard outstanding entries; a later rvalid SHALL then set err_o per REQ-021.

Verification
REQ-027 Masters 0,1,2 all request with gnt always 1 -> grants in order 0,1,2,0 on consecutive cycles.
REQ-028 Master 1 requests addr 0x0000_1000 and gnt is held low for 3 cycles while master 0 also requests -> slv_req_o stays on master 1 with addr 0x1000 until gnt, then master 0 is granted.
REQ-029 Grants issued to masters 2,0,1 with rvalid returning rdata 0xA,0xB,0xC -> rvalid reaches masters 2,0,1 respectively with those rdata values.
REQ-030 MAX_OUTSTANDING=4 and 4 grants with no rvalid -> outstanding_o=4 and slv_req_o.req=0; one rvalid -> next cycle grant resumes and outstanding_o returns to 4.
REQ-031 rvalid while outstanding_o=0 -> err_o=1, no master sees rvalid, and err_o stays 1 until rst_ni=0.
REQ-032 rst_ni asserted with 2 outstanding transactions -> outstanding_o=0 and rr_ptr=0 immediately (asynchronously), and the first grant after reset goes to master 0.
